// File: rtl/npu_pkg.sv
// Shared constants and FSM state type for the NPU activation skewer.
// Imported by the skewer top, its stream interface and the vector FIFO.
package npu_pkg;

  localparam int NPU_DW    = 8;
  localparam int NPU_ROWS  = 3;
  localparam int NPU_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } npu_state_e;

endpackage

// File: rtl/npu_act_skewer_if.sv
// Upstream activation-vector stream: one ROWS-lane vector per valid/ready handshake.
// s_last tags the final vector of a matrix.
interface npu_act_skewer_if
  import npu_pkg::*;
#(
  parameter int DW   = NPU_DW,
  parameter int ROWS = NPU_ROWS
);

  logic                 s_valid;
  logic                 s_ready;
  logic [ROWS*DW-1:0]   s_data;
  logic                 s_last;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);

endinterface

// File: rtl/npu_vec_fifo.sv
// Synchronous FIFO holding {last,vector} entries, with registered full/empty flags.
// Read data is presented combinationally from the head entry so a pop consumes it same cycle.
module npu_vec_fifo
  import npu_pkg::*;
#(
  parameter int WIDTH = NPU_ROWS * NPU_DW + 1,
  parameter int DEPTH = NPU_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_s, do_pop_s;

  // Pointer/count bookkeeping; a push while full is dropped, the pop still proceeds.
  always_comb begin
    do_push_s = push_i && !full_q;
    do_pop_s  = pop_i && !empty_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == {CW{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule

// File: rtl/npu_act_skewer.sv
// Buffers activation vectors and replays them as a diagonal wavefront into the systolic
// array: lane r is delayed r advance steps, then the triangle is flushed with zeros.
module npu_act_skewer
  import npu_pkg::*;
#(
  parameter int DW    = NPU_DW,
  parameter int ROWS  = NPU_ROWS,
  parameter int DEPTH = NPU_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  npu_act_skewer_if.slave      s,
  output logic [ROWS*DW-1:0]   m_left,
  output logic                 m_en,
  output logic                 busy,
  output logic                 done
);

  localparam int FW  = ROWS * DW + 1;
  localparam int DCW = (ROWS > 2) ? $clog2(ROWS) : 1;

  logic [FW-1:0]            fifo_rd_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [$clog2(DEPTH):0]   fifo_count_s;
  logic [ROWS*DW-1:0]       rd_vec_s;
  logic                     rd_last_s;

  npu_state_e               state_q, state_d;
  logic [DCW-1:0]           drain_cnt_q, drain_cnt_d;
  logic                     m_en_q, m_en_d;
  logic                     done_q, done_d;
  logic                     pop_s;
  logic                     adv_s;
  logic                     drain_s;

  npu_vec_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (s.s_valid),
    .wr_data_i ({s.s_last, s.s_data}),
    .pop_i     (pop_s),
    .rd_data_o (fifo_rd_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_count_s)
  );

  assign s.s_ready = ~fifo_full_s;
  assign rd_vec_s  = fifo_rd_s[FW-2:0];
  assign rd_last_s = fifo_rd_s[FW-1];
  assign drain_s   = (state_q == ST_DRAIN);

  // Sequencer: stream pops while data is queued, then ROWS-1 zero-fill steps flush the triangle.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pop_s       = 1'b0;
    adv_s       = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_count_s != '0) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
          adv_s = 1'b1;
          if (rd_last_s) begin
            if (ROWS == 1) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d     = ST_DRAIN;
              drain_cnt_d = '0;
            end
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        adv_s = 1'b1;
        if (drain_cnt_q == DCW'(ROWS - 2)) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        drain_cnt_d = '0;
      end
    endcase
    m_en_d = adv_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      m_en_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      m_en_q      <= m_en_d;
      done_q      <= done_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DW-1:0] stg_q [r+1];
    logic [DW-1:0] stg_d [r+1];

    // Lane r delay line: stage 0 loads the element (zero while draining), shifts only on advance.
    always_comb begin
      stg_d = stg_q;
      if (adv_s) begin
        stg_d[0] = drain_s ? {DW{1'b0}} : rd_vec_s[r*DW +: DW];
        for (int k = 1; k <= r; k++) begin
          stg_d[k] = stg_q[k-1];
        end
      end else begin
        stg_d = stg_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) begin
          stg_q[k] <= '0;
        end
      end else begin
        stg_q <= stg_d;
      end
    end

    assign m_left[r*DW +: DW] = stg_q[r];
  end

  assign m_en = m_en_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_npu_act_skewer.sv
// Directed bench for npu_act_skewer: wavefront shape, bubbles, FIFO full, reset abort,
// back-to-back matrices. Expected lanes come from hand tables or a small wavefront model.
module tb_npu_act_skewer;
  import npu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] m_left;
  logic        m_en, busy, done;

  npu_act_skewer_if #(.DW(8), .ROWS(3)) sif ();

  npu_act_skewer #(.DW(8), .ROWS(3), .DEPTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .s      (sif),
    .m_left (m_left),
    .m_en   (m_en),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [23:0] qm [$];
  int          men_cyc [$];
  int          done_cyc [$];
  logic [23:0] mv [20];
  logic        seen_stall = 1'b0;

  // Record every advance cycle and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (m_en) begin
      qm.push_back(m_left);
      men_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_vec(input logic [23:0] d, input logic last);
    int n = 0;
    @(negedge clk); #1;
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = last;
    while (!sif.s_ready && n < 100) begin
      seen_stall = 1'b1;
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) chk("push_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (3) begin
      @(negedge clk); #1;
    end
    chk("done_count", 32'(done_cnt), 32'(target));
  endtask

  function automatic logic [7:0] model_lane(input int first, input int n, input int r, input int s);
    int          idx;
    logic [23:0] v;
    idx = s - r;
    if (idx >= 0 && idx < n) begin
      v = mv[first + idx];
      return v[r*8 +: 8];
    end
    return 8'h00;
  endfunction

  task automatic check_matrix(input int first, input int n, input int qbase, input string tag);
    logic [23:0] t;
    for (int s = 0; s < n + 2; s++) begin
      t = qm[qbase + s];
      for (int r = 0; r < 3; r++) chk(tag, {24'd0, t[r*8 +: 8]}, {24'd0, model_lane(first, n, r, s)});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int qb, db, mb, n;
    int e0 [5] = '{1, 4, 7, 0, 0};
    int e1 [5] = '{0, 2, 5, 8, 0};
    int e2 [5] = '{0, 0, 3, 6, 9};
    logic [23:0] t;

    sif.s_valid = 1'b0;
    sif.s_data  = 24'h0;
    sif.s_last  = 1'b0;
    mv[0] = 24'h030201; mv[1] = 24'h060504; mv[2] = 24'h090807;
    mv[3] = 24'h131211; mv[4] = 24'h161514; mv[5] = 24'h191817;
    for (int i = 0; i < 12; i++) mv[6 + i] = {8'(8'hC0 + i), 8'(8'hB0 + i), 8'(8'hA0 + i)};

    // Reset state
    do_reset();
    @(negedge clk); #1;
    chk("rst_m_left", {8'd0, m_left}, 32'd0);
    chk("rst_m_en", {31'd0, m_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_s_ready", {31'd0, sif.s_ready}, 32'd1);

    // Single 3-vector matrix against the hand-derived wavefront
    qb = qm.size(); db = done_cnt; mb = men_cyc.size();
    push_vec(mv[0], 1'b0); push_vec(mv[1], 1'b0); push_vec(mv[2], 1'b1);
    wait_done(db + 1);
    chk("single_len", 32'(qm.size() - qb), 32'd5);
    for (int s = 0; s < 5; s++) begin
      t = qm[qb + s];
      chk("single_lane0", {24'd0, t[7:0]}, 32'(e0[s]));
      chk("single_lane1", {24'd0, t[15:8]}, 32'(e1[s]));
      chk("single_lane2", {24'd0, t[23:16]}, 32'(e2[s]));
    end
    chk("single_men_span", 32'(men_cyc[mb + 4] - men_cyc[mb]), 32'd4);
    chk("single_done_at", 32'(done_cyc[db]), 32'(men_cyc[mb + 4]));
    chk("single_idle_busy", {31'd0, busy}, 32'd0);

    // Bubble: vec0, four idle cycles, then vec1 as last
    qb = qm.size(); db = done_cnt; mb = men_cyc.size();
    push_vec(mv[0], 1'b0);
    repeat (4) begin
      @(negedge clk); #1;
    end
    chk("bubble_m_en", {31'd0, m_en}, 32'd0);
    chk("bubble_hold", {8'd0, m_left}, 32'h000001);
    chk("bubble_busy", {31'd0, busy}, 32'd1);
    push_vec(mv[1], 1'b1);
    wait_done(db + 1);
    chk("bubble_len", 32'(qm.size() - qb), 32'd4);
    check_matrix(0, 2, qb, "bubble_lane");
    chk("bubble_gap", 32'(men_cyc[mb + 1] - men_cyc[mb] > 1), 32'd1);

    // Full FIFO: single-vector matrices pile up while each drains
    qb = qm.size(); db = done_cnt;
    seen_stall = 1'b0;
    for (int i = 0; i < 12; i++) push_vec(mv[6 + i], 1'b1);
    wait_done(db + 12);
    chk("full_seen_stall", {31'd0, seen_stall}, 32'd1);
    chk("full_len", 32'(qm.size() - qb), 32'd36);
    for (int m = 0; m < 12; m++) check_matrix(6 + m, 1, qb + 3 * m, "full_lane");

    // Reset on the second advance aborts without a done pulse
    db = done_cnt;
    push_vec(mv[0], 1'b0); push_vec(mv[1], 1'b0); push_vec(mv[2], 1'b1);
    qb = qm.size() - 1;
    n = 0;
    while (qm.size() - qb < 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("abort_m_left", {8'd0, m_left}, 32'd0);
    chk("abort_m_en", {31'd0, m_en}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_s_ready", {31'd0, sif.s_ready}, 32'd1);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
    end
    chk("abort_no_done", 32'(done_cnt), 32'(db));
    qb = qm.size();
    push_vec(mv[0], 1'b0); push_vec(mv[1], 1'b0); push_vec(mv[2], 1'b1);
    wait_done(db + 1);
    chk("rerun_len", 32'(qm.size() - qb), 32'd5);
    check_matrix(0, 3, qb, "rerun_lane");

    // Two matrices queued back to back
    qb = qm.size(); db = done_cnt; mb = men_cyc.size();
    for (int i = 0; i < 6; i++) push_vec(mv[i], (i == 2 || i == 5));
    wait_done(db + 2);
    chk("b2b_len", 32'(qm.size() - qb), 32'd10);
    check_matrix(0, 3, qb, "b2b_first");
    check_matrix(3, 3, qb + 5, "b2b_second");
    chk("b2b_restart", 32'(men_cyc[mb + 5]), 32'(done_cyc[db] + 2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
